// File: rtl/acondicionador_botones.sv
// Pushbutton conditioner for the DPWM frequency selector: per button a 2-FF
// synchroniser, a debounce FSM and a registered single-cycle press pulse.

module acond_boton #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic evento,
    output logic estable
);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    estado_t          estado, estado_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync1, s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1  <= 1'b0;
            s      <= 1'b0;
            estado <= IDLE;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            s      <= sync1;
            estado <= estado_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = cnt;
        evento     = 1'b0;
        case (estado)
            IDLE:      if (s) estado_nxt = PRESS_CHK;
            PRESS_CHK: begin
                if (!s) estado_nxt = IDLE;
                else if (cnt == CNT_MAX) begin
                    estado_nxt = HELD;
                    evento     = 1'b1;
                end else cnt_nxt = cnt + CNT_W'(1);
            end
            HELD:      if (!s) estado_nxt = REL_CHK;
            REL_CHK: begin
                if (s) estado_nxt = HELD;
                else if (cnt == CNT_MAX) estado_nxt = IDLE;
                else cnt_nxt = cnt + CNT_W'(1);
            end
            default:   estado_nxt = IDLE;
        endcase
        // Every state change starts the next debounce window from zero.
        if (estado_nxt != estado) cnt_nxt = '0;
    end

    assign estable = (estado == HELD) || (estado == REL_CHK);

endmodule

module acondicionador_botones #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       enable,
    input  logic       boton_up_raw,
    input  logic       boton_down_raw,
    output logic       pulso_aumento,
    output logic       pulso_disminuye,
    output logic [1:0] boton_estable
);

    logic [1:0] raw;
    logic [1:0] evento;

    assign raw = {boton_down_raw, boton_up_raw};

    for (genvar i = 0; i < 2; i++) begin : g_boton
        acond_boton #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_boton (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .raw    (raw[i]),
            .evento (evento[i]),
            .estable(boton_estable[i])
        );
    end

    // Coincident presses are ambiguous for the counter, so both are dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pulso_aumento   <= 1'b0;
            pulso_disminuye <= 1'b0;
        end else begin
            pulso_aumento   <= enable & evento[0] & ~evento[1];
            pulso_disminuye <= enable & evento[1] & ~evento[0];
        end
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Bench for acondicionador_botones: directed scenarios plus random button
// activity, checked every cycle against a run-length reference model.

module tb_acondicionador_botones;

    localparam int N = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       enable = 1'b1;
    logic       boton_up_raw = 1'b0;
    logic       boton_down_raw = 1'b0;
    logic       pulso_aumento, pulso_disminuye;
    logic [1:0] boton_estable;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_up  = 0;
    int cnt_dn  = 0;
    bit chk_on  = 1'b0;

    acondicionador_botones #(.DEBOUNCE_CYCLES(N), .CNT_W(4)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .enable         (enable),
        .boton_up_raw   (boton_up_raw),
        .boton_down_raw (boton_down_raw),
        .pulso_aumento  (pulso_aumento),
        .pulso_disminuye(pulso_disminuye),
        .boton_estable  (boton_estable)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a button's debounced level flips once N+1 consecutive
    // synchronised samples disagree with it; a 0->1 flip is a press event.
    int         run [2];
    logic       lvl [2];
    logic       d1 [2];
    logic       d2 [2];
    logic       exp_up = 1'b0, exp_dn = 1'b0;
    logic [1:0] exp_est = 2'b00;

    always @(posedge CLK or negedge RST_N) begin : model
        logic [1:0] rv, ev;
        logic       s;
        if (!RST_N) begin
            for (int b = 0; b < 2; b++) begin
                run[b] = 0; lvl[b] = 1'b0; d1[b] = 1'b0; d2[b] = 1'b0;
            end
            exp_up = 1'b0; exp_dn = 1'b0; exp_est = 2'b00;
        end else begin
            rv = {boton_down_raw, boton_up_raw};
            ev = 2'b00;
            for (int b = 0; b < 2; b++) begin
                s     = d2[b];
                d2[b] = d1[b];
                d1[b] = rv[b];
                run[b] = (s != lvl[b]) ? run[b] + 1 : 0;
                if (run[b] == N + 1) begin
                    lvl[b] = s;
                    run[b] = 0;
                    ev[b]  = s;
                end
            end
            exp_up  = enable & ev[0] & ~ev[1];
            exp_dn  = enable & ev[1] & ~ev[0];
            exp_est = {lvl[1], lvl[0]};
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("pulso_aumento", {31'b0, pulso_aumento}, {31'b0, exp_up});
            chk("pulso_disminuye", {31'b0, pulso_disminuye}, {31'b0, exp_dn});
            chk("boton_estable", {30'b0, boton_estable}, {30'b0, exp_est});
            cnt_up += int'(pulso_aumento);
            cnt_dn += int'(pulso_disminuye);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic clr;
        cnt_up = 0;
        cnt_dn = 0;
    endtask

    int hu, hd, he;

    initial begin
        #1 RST_N = 1'b0;
        cyc(3);
        chk("rst_up", {31'b0, pulso_aumento}, 32'd0);
        chk("rst_dn", {31'b0, pulso_disminuye}, 32'd0);
        chk("rst_est", {30'b0, boton_estable}, 32'd0);
        RST_N = 1'b1;
        chk_on = 1'b1;
        cyc(2);

        // T1: single press, exact latency
        clr();
        boton_up_raw = 1'b1;
        cyc(10);
        chk("t1_before", {31'b0, pulso_aumento}, 32'd0);
        cyc(1);
        chk("t1_pulse", {31'b0, pulso_aumento}, 32'd1);
        cyc(1);
        chk("t1_after", {31'b0, pulso_aumento}, 32'd0);
        cyc(27);
        chk("t1_est", {30'b0, boton_estable}, 32'd1);
        chk("t1_count", cnt_up, 32'd1);
        boton_up_raw = 1'b0;
        cyc(20);

        // T2: bouncing contact then steady press
        clr();
        for (int i = 0; i < 5; i++) begin
            boton_up_raw = ~i[0];
            cyc(3);
        end
        boton_up_raw = 1'b1;
        cyc(20);
        chk("t2_count", cnt_up, 32'd1);

        // T3: short release glitch keeps the button held, long one releases it
        clr();
        boton_up_raw = 1'b0;
        cyc(5);
        boton_up_raw = 1'b1;
        cyc(15);
        chk("t3_est_held", {31'b0, boton_estable[0]}, 32'd1);
        chk("t3_count", cnt_up, 32'd0);
        boton_up_raw = 1'b0;
        cyc(12);
        chk("t3_est_rel", {31'b0, boton_estable[0]}, 32'd0);
        cyc(8);

        // T4: simultaneous presses are suppressed
        clr();
        boton_up_raw = 1'b1;
        boton_down_raw = 1'b1;
        cyc(20);
        chk("t4_est", {30'b0, boton_estable}, 32'd3);
        chk("t4_up", cnt_up, 32'd0);
        chk("t4_dn", cnt_dn, 32'd0);
        boton_up_raw = 1'b0;
        boton_down_raw = 1'b0;
        cyc(20);
        boton_down_raw = 1'b1;
        cyc(20);
        chk("t4_dn_alone", cnt_dn, 32'd1);
        boton_down_raw = 1'b0;
        cyc(20);

        // T5: events while disabled are dropped, not queued
        clr();
        enable = 1'b0;
        boton_up_raw = 1'b1;
        cyc(20);
        enable = 1'b1;
        cyc(10);
        chk("t5_dropped", cnt_up, 32'd0);
        boton_up_raw = 1'b0;
        cyc(20);
        boton_up_raw = 1'b1;
        cyc(20);
        chk("t5_repress", cnt_up, 32'd1);
        boton_up_raw = 1'b0;
        cyc(20);

        // T6: reset in the middle of the press window
        clr();
        boton_up_raw = 1'b1;
        cyc(7);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_up", {31'b0, pulso_aumento}, 32'd0);
        chk("t6_rst_est", {30'b0, boton_estable}, 32'd0);
        cyc(3);
        RST_N = 1'b1;
        cyc(10);
        chk("t6_before", {31'b0, pulso_aumento}, 32'd0);
        cyc(1);
        chk("t6_pulse", {31'b0, pulso_aumento}, 32'd1);
        cyc(10);
        chk("t6_count", cnt_up, 32'd1);
        boton_up_raw = 1'b0;
        cyc(20);

        // Random button activity with occasional disable periods
        hu = 0; hd = 0; he = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hu == 0) begin
                boton_up_raw = 1'($urandom_range(0, 1));
                hu = $urandom_range(1, 22);
            end
            if (hd == 0) begin
                boton_down_raw = 1'($urandom_range(0, 1));
                hd = $urandom_range(1, 22);
            end
            if (he == 0) begin
                enable = ($urandom_range(0, 5) != 0);
                he = $urandom_range(5, 60);
            end
            hu--; hd--; he--;
            cyc(1);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
